// File: rtl/core_clock_controller.sv
// ----------------------------------------------------------------------------
// core_clock_controller
//
// Turns the divided clock into the clock that drives the SiMPLE core. The core
// can free-run, be halted, or be single-stepped with a debounced push-button.
// Only whole clock_divided high phases are passed through, so no runt pulses
// reach the core. All logic runs in the clock_100mhz domain.
//
// Optional feature: define CYCLE_COUNTER_EN to build a 32-bit counter of
// emitted core_clock rising edges. Without it, cycle_count is tied to zero.
//
// Ports:
//   clock_100mhz      in   system clock
//   reset             in   asynchronous, active-high reset
//   clock_divided     in   divided clock (registered, clock_100mhz domain)
//   run_switch        in   1 = free-run requested (asynchronous)
//   step_button       in   single-step push-button, active-high (async, bouncy)
//   halt_request      in   level halt from debug logic (synchronous)
//   core_clock        out  gated, registered clock to the core
//   core_clock_enable out  one-cycle strobe when core_clock goes 0->1
//   halted            out  1 while the FSM is in the halted state
//   cycle_count       out  number of core_clock rising edges emitted
// ----------------------------------------------------------------------------
module core_clock_controller #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned DEBOUNCE_WIDTH  = 20
) (
    input  logic        clock_100mhz,
    input  logic        reset,
    input  logic        clock_divided,
    input  logic        run_switch,
    input  logic        step_button,
    input  logic        halt_request,
    output logic        core_clock,
    output logic        core_clock_enable,
    output logic        halted,
    output logic [31:0] cycle_count
);

    localparam logic [DEBOUNCE_WIDTH-1:0] DbLast = DEBOUNCE_WIDTH'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        StHalted,
        StRunning,
        StStepWait,
        StStepHigh
    } state_e;

    // Bit 0 carries run_switch, bit 1 carries step_button.
    logic [1:0]                w_raw;
    logic [1:0]                r_sync_meta;
    logic [1:0]                r_sync;
    logic [1:0]                r_db;
    logic [DEBOUNCE_WIDTH-1:0] r_db_cnt [2];
    logic                      r_step_db_prev;
    logic                      r_div_prev;

    logic   w_step_press;
    logic   w_div_rise;
    logic   w_div_fall;
    logic   w_go;

    state_e r_state;
    state_e w_state_next;
    logic   r_core_clock;
    logic   w_core_clock_next;
    logic   r_core_clock_enable;

    assign w_raw = {step_button, run_switch};

    // Two-flop synchronizer followed by a counter debouncer per input. A new
    // level is accepted only after DEBOUNCE_CYCLES consecutive differing samples.
    always_ff @(posedge clock_100mhz or posedge reset) begin
        if (reset) begin
            r_sync_meta <= '0;
            r_sync      <= '0;
            r_db        <= '0;
            r_db_cnt[0] <= '0;
            r_db_cnt[1] <= '0;
        end else begin
            r_sync_meta <= w_raw;
            r_sync      <= r_sync_meta;
            for (int i = 0; i < 2; i++) begin
                if (r_sync[i] != r_db[i]) begin
                    if (r_db_cnt[i] == DbLast) begin
                        r_db[i]     <= r_sync[i];
                        r_db_cnt[i] <= '0;
                    end else begin
                        r_db_cnt[i] <= r_db_cnt[i] + DEBOUNCE_WIDTH'(1);
                    end
                end else begin
                    r_db_cnt[i] <= '0;
                end
            end
        end
    end

    always_ff @(posedge clock_100mhz or posedge reset) begin
        if (reset) begin
            r_step_db_prev <= 1'b0;
            r_div_prev     <= 1'b0;
        end else begin
            r_step_db_prev <= r_db[1];
            r_div_prev     <= clock_divided;
        end
    end

    assign w_step_press = r_db[1] & ~r_step_db_prev;
    assign w_div_rise   = clock_divided & ~r_div_prev;
    assign w_div_fall   = ~clock_divided & r_div_prev;
    assign w_go         = r_db[0] & ~halt_request;

    always_comb begin
        w_state_next      = r_state;
        w_core_clock_next = r_core_clock;
        unique case (r_state)
            StHalted: begin
                w_core_clock_next = 1'b0;
                // Run wins over a simultaneous step press.
                if (w_go) begin
                    w_state_next = StRunning;
                end else if (w_step_press) begin
                    w_state_next = StStepWait;
                end
            end
            StRunning: begin
                if (w_div_rise) begin
                    w_core_clock_next = 1'b1;
                end else if (w_div_fall) begin
                    w_core_clock_next = 1'b0;
                end
                // Stopping never truncates a high phase: with the clock high,
                // wait for the divided clock to fall before halting.
                if (!w_go) begin
                    if (!r_core_clock) begin
                        w_core_clock_next = 1'b0;
                        w_state_next      = StHalted;
                    end else if (w_div_fall) begin
                        w_state_next = StHalted;
                    end
                end
            end
            StStepWait: begin
                if (w_div_rise) begin
                    w_core_clock_next = 1'b1;
                    w_state_next      = StStepHigh;
                end
            end
            StStepHigh: begin
                if (w_div_fall) begin
                    w_core_clock_next = 1'b0;
                    w_state_next      = StHalted;
                end
            end
        endcase
    end

    always_ff @(posedge clock_100mhz or posedge reset) begin
        if (reset) begin
            r_state             <= StHalted;
            r_core_clock        <= 1'b0;
            r_core_clock_enable <= 1'b0;
        end else begin
            r_state             <= w_state_next;
            r_core_clock        <= w_core_clock_next;
            r_core_clock_enable <= w_core_clock_next & ~r_core_clock;
        end
    end

    assign core_clock        = r_core_clock;
    assign core_clock_enable = r_core_clock_enable;
    assign halted            = (r_state == StHalted);

`ifdef CYCLE_COUNTER_EN
    logic [31:0] r_cycle_count;

    always_ff @(posedge clock_100mhz or posedge reset) begin
        if (reset) begin
            r_cycle_count <= 32'h0;
        end else if (r_core_clock_enable) begin
            r_cycle_count <= r_cycle_count + 32'h1;
        end
    end

    assign cycle_count = r_cycle_count;
`else
    assign cycle_count = 32'h0;
`endif

endmodule

// File: tb/tb_core_clock_controller.sv
// ----------------------------------------------------------------------------
// Testbench for core_clock_controller with a short debounce (4 cycles) and a
// divided clock of period 8 (4 high, 4 low). Outputs are sampled on the
// falling edge of clock_100mhz; inputs are driven right after sampling.
// Expected cycle_count values assume CYCLE_COUNTER_EN follows the same
// definition as the RTL build; without it the counter must read zero.
// ----------------------------------------------------------------------------
module tb_core_clock_controller;

`ifdef CYCLE_COUNTER_EN
    localparam bit CntOn = 1'b1;
`else
    localparam bit CntOn = 1'b0;
`endif

    logic        clock_100mhz  = 1'b0;
    logic        reset         = 1'b1;
    logic        clock_divided = 1'b0;
    logic        run_switch    = 1'b0;
    logic        step_button   = 1'b0;
    logic        halt_request  = 1'b0;
    logic        core_clock;
    logic        core_clock_enable;
    logic        halted;
    logic [31:0] cycle_count;

    int n_checks = 0;
    int n_pass   = 0;

    // Sampled statistics, updated once per cycle by tick().
    int       tcount     = 0;
    int       rises      = 0;
    int       en_cnt     = 0;
    int       en_bad     = 0;
    int       width_bad  = 0;
    int       period_bad = 0;
    int       last_rise  = -1;
    int       hi_len     = 0;
    int       div_phase  = 0;
    logic     cc_prev    = 1'b0;
    logic     dv1        = 1'b0;
    logic     dv2        = 1'b0;
    logic [1:0] rise_hist = 2'b00;

    core_clock_controller #(
        .DEBOUNCE_CYCLES(4),
        .DEBOUNCE_WIDTH (3)
    ) dut (
        .clock_100mhz     (clock_100mhz),
        .reset            (reset),
        .clock_divided    (clock_divided),
        .run_switch       (run_switch),
        .step_button      (step_button),
        .halt_request     (halt_request),
        .core_clock       (core_clock),
        .core_clock_enable(core_clock_enable),
        .halted           (halted),
        .cycle_count      (cycle_count)
    );

    always #5 clock_100mhz = ~clock_100mhz;

    // Registered divider model: 4 cycles high, 4 cycles low.
    always begin
        @(posedge clock_100mhz);
        #1;
        div_phase     = (div_phase + 1) % 8;
        clock_divided = (div_phase < 4);
    end

    task automatic tick();
        @(negedge clock_100mhz);
        tcount++;
        if (core_clock === 1'b1 && cc_prev === 1'b0) begin
            rises++;
            rise_hist = {dv2, dv1};
            if (last_rise >= 0 && (tcount - last_rise) != 8) period_bad++;
            last_rise = tcount;
        end
        if (core_clock_enable === 1'b1) en_cnt++;
        if (core_clock_enable !== (core_clock & ~cc_prev)) en_bad++;
        if (core_clock === 1'b1) begin
            hi_len++;
        end else if (cc_prev === 1'b1) begin
            if (hi_len != 4) width_bad++;
            hi_len = 0;
        end
        cc_prev = core_clock;
        dv2     = dv1;
        dv1     = clock_divided;
    endtask

    task automatic clear_stats();
        rises      = 0;
        en_cnt     = 0;
        en_bad     = 0;
        width_bad  = 0;
        period_bad = 0;
        last_rise  = -1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (5) tick();
        n_checks++;
        if (core_clock !== 1'b0) $display("FAIL reset_core_clock: got %b want 0", core_clock);
        else n_pass++;
        n_checks++;
        if (halted !== 1'b1) $display("FAIL reset_halted: got %b want 1", halted);
        else n_pass++;
        n_checks++;
        if (core_clock_enable !== 1'b0) $display("FAIL reset_enable: got %b want 0", core_clock_enable);
        else n_pass++;
        n_checks++;
        if (cycle_count !== 32'h0) $display("FAIL reset_count: got %0d want 0", cycle_count);
        else n_pass++;
        reset = 1'b0;
        clear_stats();
        repeat (200) tick();
        n_checks++;
        if (rises !== 0) $display("FAIL idle_no_pulse: got %0d want 0", rises);
        else n_pass++;
        n_checks++;
        if (en_cnt !== 0) $display("FAIL idle_no_enable: got %0d want 0", en_cnt);
        else n_pass++;
        n_checks++;
        if (halted !== 1'b1) $display("FAIL idle_halted: got %b want 1", halted);
        else n_pass++;
        n_checks++;
        if (cycle_count !== 32'h0) $display("FAIL idle_count: got %0d want 0", cycle_count);
        else n_pass++;
    endtask

    task automatic test_run();
        int k;
        clear_stats();
        repeat (10) tick();
        run_switch = 1'b1;
        repeat (5) tick();
        n_checks++;
        if (halted !== 1'b1) $display("FAIL run_latency_early: got %b want 1", halted);
        else n_pass++;
        repeat (2) tick();
        n_checks++;
        if (halted !== 1'b0) $display("FAIL run_latency: got %b want 0", halted);
        else n_pass++;
        clear_stats();
        k = 0;
        while (rises == 0 && k < 20) begin
            tick();
            k++;
        end
        n_checks++;
        if (rises !== 1) $display("FAIL run_first_rise: got %0d want 1", rises);
        else n_pass++;
        n_checks++;
        if (rise_hist !== 2'b01) $display("FAIL run_rise_lag: got %b want 01", rise_hist);
        else n_pass++;
        repeat (73) tick();
        n_checks++;
        if (rises !== 10) $display("FAIL run_pulses: got %0d want 10", rises);
        else n_pass++;
        n_checks++;
        if (en_cnt !== 10) $display("FAIL run_enables: got %0d want 10", en_cnt);
        else n_pass++;
        n_checks++;
        if (en_bad !== 0) $display("FAIL run_enable_align: got %0d want 0", en_bad);
        else n_pass++;
        n_checks++;
        if (width_bad !== 0) $display("FAIL run_width: got %0d want 0", width_bad);
        else n_pass++;
        n_checks++;
        if (period_bad !== 0) $display("FAIL run_period: got %0d want 0", period_bad);
        else n_pass++;
        n_checks++;
        if (cycle_count !== (CntOn ? 32'd10 : 32'd0))
            $display("FAIL run_count: got %0d want %0d", cycle_count, CntOn ? 10 : 0);
        else n_pass++;
    endtask

    task automatic test_run_drop();
        int k;
        int r0;
        r0 = rises;
        k  = 0;
        while (rises == r0 && k < 12) begin
            tick();
            k++;
        end
        n_checks++;
        if (rises !== r0 + 1) $display("FAIL drop_sync_rise: got %0d want %0d", rises, r0 + 1);
        else n_pass++;
        // Debounced run falls 6 edges later: one cycle into the next pulse.
        repeat (3) tick();
        run_switch = 1'b0;
        clear_stats();
        k = 0;
        while (halted !== 1'b1 && k < 20) begin
            tick();
            k++;
        end
        n_checks++;
        if (k !== 9) $display("FAIL drop_halt_edge: got %0d want 9", k);
        else n_pass++;
        n_checks++;
        if (core_clock !== 1'b0) $display("FAIL drop_clock_low: got %b want 0", core_clock);
        else n_pass++;
        n_checks++;
        if (rises !== 1) $display("FAIL drop_last_pulse: got %0d want 1", rises);
        else n_pass++;
        n_checks++;
        if (width_bad !== 0) $display("FAIL drop_width: got %0d want 0", width_bad);
        else n_pass++;
        repeat (40) tick();
        n_checks++;
        if (rises !== 1) $display("FAIL drop_no_more: got %0d want 1", rises);
        else n_pass++;
        n_checks++;
        if (cycle_count !== (CntOn ? 32'd12 : 32'd0))
            $display("FAIL drop_count: got %0d want %0d", cycle_count, CntOn ? 12 : 0);
        else n_pass++;
    endtask

    task automatic test_step();
        bit saw_low;
        saw_low = 1'b0;
        clear_stats();
        step_button = 1'b1;
        repeat (12) begin
            tick();
            if (halted === 1'b0) saw_low = 1'b1;
        end
        step_button = 1'b0;
        repeat (30) begin
            tick();
            if (halted === 1'b0) saw_low = 1'b1;
        end
        n_checks++;
        if (rises !== 1) $display("FAIL step_one_pulse: got %0d want 1", rises);
        else n_pass++;
        n_checks++;
        if (en_cnt !== 1) $display("FAIL step_one_enable: got %0d want 1", en_cnt);
        else n_pass++;
        n_checks++;
        if (width_bad !== 0) $display("FAIL step_width: got %0d want 0", width_bad);
        else n_pass++;
        n_checks++;
        if (saw_low !== 1'b1) $display("FAIL step_not_halted: got %b want 1", saw_low);
        else n_pass++;
        n_checks++;
        if (halted !== 1'b1) $display("FAIL step_back_halted: got %b want 1", halted);
        else n_pass++;
        n_checks++;
        if (cycle_count !== (CntOn ? 32'd13 : 32'd0))
            $display("FAIL step_count: got %0d want %0d", cycle_count, CntOn ? 13 : 0);
        else n_pass++;
        clear_stats();
        for (int i = 0; i < 40; i++) begin
            step_button = ((i / 2) % 2 == 0);
            tick();
        end
        step_button = 1'b0;
        repeat (30) tick();
        n_checks++;
        if (rises !== 0) $display("FAIL bounce_no_pulse: got %0d want 0", rises);
        else n_pass++;
        n_checks++;
        if (halted !== 1'b1) $display("FAIL bounce_halted: got %b want 1", halted);
        else n_pass++;
    endtask

    task automatic test_halt_request();
        int k;
        run_switch = 1'b1;
        clear_stats();
        k = 0;
        while (rises == 0 && k < 30) begin
            tick();
            k++;
        end
        n_checks++;
        if (rises !== 1) $display("FAIL halt_run_start: got %0d want 1", rises);
        else n_pass++;
        tick();
        halt_request = 1'b1;
        repeat (2) tick();
        n_checks++;
        if (core_clock !== 1'b1 || halted !== 1'b0)
            $display("FAIL halt_hold_high: got clk=%b halted=%b want clk=1 halted=0", core_clock, halted);
        else n_pass++;
        tick();
        n_checks++;
        if (core_clock !== 1'b0 || halted !== 1'b1)
            $display("FAIL halt_at_fall: got clk=%b halted=%b want clk=0 halted=1", core_clock, halted);
        else n_pass++;
        n_checks++;
        if (width_bad !== 0) $display("FAIL halt_width: got %0d want 0", width_bad);
        else n_pass++;
        clear_stats();
        step_button = 1'b1;
        repeat (8) tick();
        step_button = 1'b0;
        repeat (30) tick();
        n_checks++;
        if (rises !== 1) $display("FAIL halt_step_pulse: got %0d want 1", rises);
        else n_pass++;
        n_checks++;
        if (halted !== 1'b1) $display("FAIL halt_step_halted: got %b want 1", halted);
        else n_pass++;
        n_checks++;
        if (cycle_count !== (CntOn ? 32'd15 : 32'd0))
            $display("FAIL halt_count: got %0d want %0d", cycle_count, CntOn ? 15 : 0);
        else n_pass++;
        clear_stats();
        halt_request = 1'b0;
        tick();
        n_checks++;
        if (halted !== 1'b0) $display("FAIL resume_running: got %b want 0", halted);
        else n_pass++;
        k = 0;
        while (rises == 0 && k < 12) begin
            tick();
            k++;
        end
        n_checks++;
        if (rises !== 1 || rise_hist !== 2'b01)
            $display("FAIL resume_at_rise: got rises=%0d hist=%b want rises=1 hist=01", rises, rise_hist);
        else n_pass++;
        run_switch = 1'b0;
        k = 0;
        while (halted !== 1'b1 && k < 30) begin
            tick();
            k++;
        end
        n_checks++;
        if (halted !== 1'b1) $display("FAIL resume_stop: got %b want 1", halted);
        else n_pass++;
        repeat (10) tick();
    endtask

    task automatic test_reset_mid_step();
        int k;
        clear_stats();
        step_button = 1'b1;
        repeat (8) tick();
        step_button = 1'b0;
        k = 0;
        while (core_clock !== 1'b1 && k < 20) begin
            tick();
            k++;
        end
        n_checks++;
        if (core_clock !== 1'b1 || halted !== 1'b0)
            $display("FAIL mid_step_high: got clk=%b halted=%b want clk=1 halted=0", core_clock, halted);
        else n_pass++;
        #2;
        reset = 1'b1;
        #1;
        n_checks++;
        if (core_clock !== 1'b0) $display("FAIL mid_reset_clock: got %b want 0", core_clock);
        else n_pass++;
        n_checks++;
        if (halted !== 1'b1) $display("FAIL mid_reset_halted: got %b want 1", halted);
        else n_pass++;
        n_checks++;
        if (cycle_count !== 32'h0 || core_clock_enable !== 1'b0)
            $display("FAIL mid_reset_count: got count=%0d en=%b want 0 0", cycle_count, core_clock_enable);
        else n_pass++;
        repeat (3) tick();
        reset   = 1'b0;
        cc_prev = 1'b0;
        hi_len  = 0;
        clear_stats();
        repeat (40) tick();
        n_checks++;
        if (rises !== 0) $display("FAIL post_reset_no_step: got %0d want 0", rises);
        else n_pass++;
        n_checks++;
        if (halted !== 1'b1) $display("FAIL post_reset_halted: got %b want 1", halted);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_run();
        test_run_drop();
        test_step();
        test_halt_request();
        test_reset_mid_step();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
